// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from ptr+1 with wrap.
module rr_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int p_REQ       = 4,
  parameter int p_IDX_WIDTH = idx_width(p_REQ)
) (
  input  logic [p_REQ-1:0]       iv_req,
  input  logic [p_IDX_WIDTH-1:0] iv_ptr,
  output logic                   o_any,
  output logic [p_IDX_WIDTH-1:0] ov_idx,
  output logic [p_REQ-1:0]       ov_onehot
);

  logic [p_IDX_WIDTH-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest hit is the one left standing.
  always_comb begin
    o_any     = |iv_req;
    ov_idx    = '0;
    ov_onehot = '0;
    cand      = '0;
    for (int off = p_REQ; off >= 1; off--) begin
      cand = p_IDX_WIDTH'((int'(iv_ptr) + off) % p_REQ);
      if (iv_req[cand]) begin
        ov_idx = cand;
      end
    end
    if (o_any) begin
      ov_onehot[ov_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UartTx between p_REQ requesters.
// Optional macro UART_TX_ARB_PRIO0_EN gives requester 0 fixed highest priority.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int p_DATA_WIDTH = 8,
  parameter int p_REQ        = 4,
  parameter int p_IDX_WIDTH  = idx_width(p_REQ)
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [p_REQ-1:0]             iv_req,
  input  logic [p_REQ*p_DATA_WIDTH-1:0] iv_req_data,
  output logic [p_REQ-1:0]             ov_grant,
  output logic [p_IDX_WIDTH-1:0]       ov_owner,
  output logic                         o_busy,
  output logic [p_DATA_WIDTH-1:0]      ov_tx_data,
  output logic                         o_tx_data_ready,
  input  logic                         i_tx_busy
);

  arb_state_e               state_q, state_d;
  logic [p_IDX_WIDTH-1:0]   ptr_q, ptr_d;
  logic [p_REQ-1:0]         pick_req, pick_onehot, win_onehot;
  logic [p_IDX_WIDTH-1:0]   pick_idx, win_idx;
  logic                     pick_any, win_any, upd_ptr, load;
  logic [p_DATA_WIDTH-1:0]  words [p_REQ];

  always_comb begin
    for (int k = 0; k < p_REQ; k++) begin
      words[k] = iv_req_data[k*p_DATA_WIDTH +: p_DATA_WIDTH];
    end
  end

`ifdef UART_TX_ARB_PRIO0_EN
  assign pick_req = iv_req & ~p_REQ'(1);
`else
  assign pick_req = iv_req;
`endif

  rr_picker #(
    .p_REQ       (p_REQ),
    .p_IDX_WIDTH (p_IDX_WIDTH)
  ) u_picker (
    .iv_req    (pick_req),
    .iv_ptr    (ptr_q),
    .o_any     (pick_any),
    .ov_idx    (pick_idx),
    .ov_onehot (pick_onehot)
  );

  // A priority win for requester 0 leaves the rotation untouched for the others.
  always_comb begin
    win_any    = pick_any;
    win_idx    = pick_idx;
    win_onehot = pick_onehot;
    upd_ptr    = 1'b1;
`ifdef UART_TX_ARB_PRIO0_EN
    if (iv_req[0]) begin
      win_any    = 1'b1;
      win_idx    = '0;
      win_onehot = p_REQ'(1);
      upd_ptr    = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_any && !i_tx_busy) begin
          load    = 1'b1;
          state_d = START;
          if (upd_ptr) ptr_d = win_idx;
        end
      end
      START:   if (i_tx_busy) state_d = SEND;
      SEND:    if (!i_tx_busy) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q         <= IDLE;
      ptr_q           <= p_IDX_WIDTH'(p_REQ - 1);
      ov_grant        <= '0;
      ov_owner        <= '0;
      ov_tx_data      <= '0;
      o_tx_data_ready <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ov_grant <= load ? win_onehot : '0;
      if (load) begin
        ov_owner        <= win_idx;
        ov_tx_data      <= words[win_idx];
        o_tx_data_ready <= 1'b1;
      end else if (state_q == START && i_tx_busy) begin
        o_tx_data_ready <= 1'b0;
      end
    end
  end

  assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural UartTx, a serial-line decoder and a
// transaction-level arbitration model (honours UART_TX_ARB_PRIO0_EN when defined).
module tb_uart_tx_arbiter;
  localparam int W = 4;
  localparam int R = 4;
  localparam int PERIOD = 2;
  localparam int FB = W + 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [R-1:0]   req;
  logic [R*W-1:0] data;
  logic [R-1:0]   grant;
  logic [1:0]     owner;
  logic           busy;
  logic [W-1:0]   tx_data;
  logic           tx_ready;
  logic           tx_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  int last_fall = -1;
  int m_ptr = R - 1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  uart_tx_arbiter #(.p_DATA_WIDTH(W), .p_REQ(R)) dut (
    .i_clk(clk), .i_reset(rst_n), .iv_req(req), .iv_req_data(data),
    .ov_grant(grant), .ov_owner(owner), .o_busy(busy), .ov_tx_data(tx_data),
    .o_tx_data_ready(tx_ready), .i_tx_busy(tx_busy));

  // Behavioural UartTx: start bit, W data bits LSB first, stop bit, PERIOD cycles each.
  logic          line;
  logic [FB-1:0] frame;
  int            bit_i, bcyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy <= 1'b0; line <= 1'b1; bit_i <= 0; bcyc <= 0;
    end else if (!tx_busy) begin
      if (tx_ready) begin
        frame <= {1'b1, tx_data, 1'b0}; tx_busy <= 1'b1; line <= 1'b0; bit_i <= 0; bcyc <= 0;
      end
    end else if (bcyc == PERIOD - 1) begin
      bcyc <= 0;
      if (bit_i == FB - 1) begin
        tx_busy <= 1'b0; line <= 1'b1;
      end else begin
        bit_i <= bit_i + 1; line <= frame[bit_i + 1];
      end
    end else begin
      bcyc <= bcyc + 1;
    end
  end

  // Serial decoder: samples each bit on its first falling clock edge.
  logic         dec_act = 1'b0;
  int           dec_cnt = 0;
  logic [W-1:0] dec_word;
  logic [W-1:0] dec_q[$];
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_act <= 1'b0; dec_q.delete();
    end else if (!dec_act) begin
      if (line == 1'b0) begin dec_act <= 1'b1; dec_cnt <= 0; end
    end else begin
      dec_cnt <= dec_cnt + 1;
      if (((dec_cnt + 1) % 2 == 0) && (dec_cnt + 1 <= 2 * W)) dec_word[(dec_cnt + 1) / 2 - 1] <= line;
      if (dec_cnt + 1 == 2 * (W + 1)) begin
        dec_act <= 1'b0;
        if (line) dec_q.push_back(dec_word);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_pick(input logic [R-1:0] r, input int ptr);
`ifdef UART_TX_ARB_PRIO0_EN
    if (r[0]) return 0;
    r[0] = 1'b0;
`endif
    for (int off = 1; off <= R; off++) if (r[(ptr + off) % R]) return (ptr + off) % R;
    return -1;
  endfunction

  task automatic run_frame(input int exp_idx, input logic [R-1:0] nreq, input logic [R*W-1:0] ndata,
                           input logic [R-1:0] mreq, output int waited);
    int w;
    logic got, stray;
    logic [W-1:0] exp_word;
    logic [R-1:0] oh;
    got = 1'b0; w = 0;
    while (!got && w < 200) begin
      @(negedge clk); w++;
      if (grant !== '0) got = 1'b1;
    end
    waited = w;
    chk("grant_seen", got, 1);
    if (!got) return;
    exp_word = data[exp_idx*W +: W];
    oh = R'(1) << exp_idx;
    chk("grant_vec", grant, oh);
    chk("owner", owner, exp_idx);
    chk("tx_data", tx_data, exp_word);
    chk("tx_ready_set", tx_ready, 1);
    chk("busy_flag", busy, 1);
    if (last_fall >= 0) chk("grant_gap", (cyc_n - last_fall) >= 2, 1);
`ifdef UART_TX_ARB_PRIO0_EN
    if (exp_idx != 0) m_ptr = exp_idx;
`else
    m_ptr = exp_idx;
`endif
    req = nreq; data = ndata;
    @(negedge clk);
    chk("grant_pulse", grant, 0);
    w = 0;
    while (!tx_busy && w < 50) begin @(negedge clk); w++; end
    chk("uart_start", tx_busy, 1);
    req = mreq;
    @(negedge clk);
    chk("ready_drop", tx_ready, 0);
    stray = 1'b0; w = 0;
    while (tx_busy && w < 200) begin
      @(negedge clk); w++;
      if (grant !== '0 || tx_data !== exp_word) stray = 1'b1;
    end
    chk("frame_quiet", stray, 0);
    chk("uart_done", tx_busy, 0);
    chk("owner_hold", owner, exp_idx);
    last_fall = cyc_n;
    chk("decoded_avail", dec_q.size() > 0, 1);
    if (dec_q.size() > 0) chk("decoded_word", dec_q.pop_front(), exp_word);
  endtask

  initial begin
    int waited, w, exp;
    logic got;
    logic [R-1:0]   cur, nreq, mreq;
    logic [R*W-1:0] ndata;

    rst_n = 1'b0; req = 4'b1111; data = 16'h4321;
    repeat (3) begin @(negedge clk); chk("reset_grant", grant, 0); end
    chk("reset_ready", tx_ready, 0);
    chk("reset_txdata", tx_data, 0);
    chk("reset_owner", owner, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;

`ifdef UART_TX_ARB_PRIO0_EN
    req = 4'b1110 | 4'b0001;
    run_frame(0, 4'b1110, 16'h4321, 4'b1110, waited);
    chk("first_latency", waited, 1);
    run_frame(1, 4'b1110, 16'h4321, 4'b1111, waited);
    run_frame(0, 4'b0100, 16'h0300, 4'b0100, waited);
`else
    run_frame(0, 4'b1111, 16'h4321, 4'b1111, waited);
    chk("first_latency", waited, 1);
    run_frame(1, 4'b1111, 16'h4321, 4'b1111, waited);
    run_frame(2, 4'b1111, 16'h4321, 4'b1111, waited);
    run_frame(3, 4'b1111, 16'h4321, 4'b1111, waited);
    run_frame(0, 4'b0100, 16'h0300, 4'b0100, waited);
`endif
    run_frame(2, 4'b0001, 16'h0307, 4'b0001, waited);
    run_frame(0, 4'b1010, 16'hC0A7, 4'b1000, waited);
    run_frame(3, 4'b0110, 16'h9A5C, 4'b0110, waited);

    // Reset while the frame from requester 1 is being serialized.
    got = 1'b0; w = 0;
    while (!got && w < 200) begin @(negedge clk); w++; if (grant !== '0) got = 1'b1; end
    chk("pre_reset_grant", grant, 4'b0010);
    w = 0;
    while (!tx_busy && w < 50) begin @(negedge clk); w++; end
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    req = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", grant, 0);
    chk("async_owner", owner, 0);
    chk("async_txdata", tx_data, 0);
    chk("async_ready", tx_ready, 0);
    chk("async_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; m_ptr = R - 1; last_fall = -1;
    run_frame(0, 4'b1111, 16'h4321, 4'b1111, waited);

    cur = 4'b1111;
    for (int i = 0; i < 30; i++) begin
      exp = ref_pick(cur, m_ptr);
      nreq = R'($urandom_range(1, 15));
      ndata = data;
      for (int k = 0; k < R; k++)
        if (k == exp || !cur[k]) ndata[k*W +: W] = W'($urandom);
      mreq = nreq & R'($urandom_range(0, 15));
      if (mreq == '0) mreq = nreq;
      run_frame(exp, nreq, ndata, mreq, waited);
      cur = mreq;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
